// File: rtl/mips_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one result bit per cycle.
// Divider is included only when MIPS_MDU_DIV_EN is defined; otherwise divide starts are ignored.
module mips_mdu #(
   parameter int unsigned N = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         flush_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] hi_o,
   output logic [N-1:0] lo_o
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic            sa_q, sa_d, sb_q, sb_d;
   logic            done_q, done_d;

   logic            accept;
   logic            op_signed;
   logic [N-1:0]    a_abs, b_abs;
   logic [N:0]      mul_sum;
   logic [2*N-1:0]  mul_acc, mul_res;

   assign op_signed = ~op_i[0];
   assign a_abs     = (op_signed && a_i[N-1]) ? ('0 - a_i) : a_i;
   assign b_abs     = (op_signed && b_i[N-1]) ? ('0 - b_i) : b_i;

   // Shift-add: add the multiplicand into the upper half, then shift the whole product right.
   assign mul_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, (b_q[0] ? a_q : '0)};
   assign mul_acc = {mul_sum, acc_q[N-1:1]};
   assign mul_res = (sa_q ^ sb_q) ? ('0 - acc_q) : acc_q;

`ifdef MIPS_MDU_DIV_EN
   logic            div_q, div_d;
   logic            bzero_q, bzero_d;
   logic [N:0]      div_r;
   logic            div_ge;
   logic [N-1:0]    div_rem;
   logic [2*N-1:0]  div_acc;
   logic [N-1:0]    quo, rem, div_hi, div_lo;

   assign accept = start_i & ~flush_i;

   // Restoring step: upper half is the partial remainder, lower half collects quotient bits.
   assign div_r   = {acc_q[2*N-1:N], a_q[N-1]};
   assign div_ge  = (div_r >= {1'b0, b_q});
   assign div_rem = div_ge ? (div_r[N-1:0] - b_q) : div_r[N-1:0];
   assign div_acc = {div_rem, acc_q[N-2:0], div_ge};

   assign quo    = acc_q[N-1:0];
   assign rem    = acc_q[2*N-1:N];
   // With b=0 the remainder already equals |a|, so only the quotient needs forcing.
   assign div_lo = bzero_q ? '1 : ((sa_q ^ sb_q) ? ('0 - quo) : quo);
   assign div_hi = sa_q ? ('0 - rem) : rem;
`else
   assign accept = start_i & ~flush_i & ~op_i[1];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MIPS_MDU_DIV_EN
      div_d   = div_q;
      bzero_d = bzero_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               a_d     = a_abs;
               b_d     = b_abs;
               sa_d    = op_signed & a_i[N-1];
               sb_d    = op_signed & b_i[N-1];
               acc_d   = '0;
               cnt_d   = CntW'(N - 1);
`ifdef MIPS_MDU_DIV_EN
               div_d   = op_i[1];
               bzero_d = (b_i == '0);
`endif
               state_d = StCalc;
            end
         end
         StCalc: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            acc_d = mul_acc;
            b_d   = b_q >> 1;
`ifdef MIPS_MDU_DIV_EN
            if (div_q) begin
               acc_d = div_acc;
               a_d   = a_q << 1;
               b_d   = b_q;
            end
`endif
            if (cnt_q == '0) state_d = StFix;
         end
         StFix: begin
            {hi_d, lo_d} = mul_res;
`ifdef MIPS_MDU_DIV_EN
            if (div_q) begin
               hi_d = div_hi;
               lo_d = div_lo;
            end
`endif
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A flush abandons whatever is in flight, including a pending write-back.
      if (flush_i) begin
         state_d = StIdle;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
         div_q   <= 1'b0;
         bzero_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef MIPS_MDU_DIV_EN
         div_q   <= div_d;
         bzero_q <= bzero_d;
`endif
      end
   end

   assign busy_o = (state_q != StIdle);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Self-checking bench for mips_mdu: directed literal cases plus randomized traffic against a
// cycle-count/arithmetic reference model. Divide expectations follow MIPS_MDU_DIV_EN.
module tb_mips_mdu;

   localparam int N = 32;
`ifdef MIPS_MDU_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mips_mdu #(.N(N)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .flush_i (flush),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, y);
      logic signed [31:0] sx, sy, q, r;
      sx = x;
      sy = y;
      case (o)
         2'd0: return longint'(sx) * longint'(sy);
         2'd1: return {32'd0, x} * {32'd0, y};
         2'd2: begin
            if (y == 32'd0) return {x, 32'hffffffff};
            if (x == 32'h80000000 && y == 32'hffffffff) return {32'd0, 32'h80000000};
            q = sx / sy;
            r = sx % sy;
            return {r, q};
         end
         default: begin
            if (y == 32'd0) return {x, 32'hffffffff};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Model: m_rem counts cycles left in the operation; result lands when it expires.
   int          m_rem = 0;
   logic [63:0] pend = '0;
   logic [31:0] exp_hi = '0, exp_lo = '0;
   logic        exp_done = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_rem    <= 0;
         exp_hi   <= '0;
         exp_lo   <= '0;
         exp_done <= 1'b0;
      end else begin
         exp_done <= 1'b0;
         if (flush) begin
            m_rem <= 0;
         end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               exp_hi   <= pend[63:32];
               exp_lo   <= pend[31:0];
               exp_done <= 1'b1;
            end
         end else if (start && (DivEn || !op[1])) begin
            pend  <= ref_op(op, a, b);
            m_rem <= N + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
         check("model done", {31'd0, done}, {31'd0, exp_done});
         check("model hi", hi, exp_hi);
         check("model lo", lo, exp_lo);
      end
   end

   // Start an op in the current cycle and wait (bounded) for done, checking timing and result.
   task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x, y,
                      input logic [31:0] eh, el);
      int lat, nbusy;
      lat   = -1;
      nbusy = 0;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) nbusy++;
      end
      check({nm, " latency"}, 32'(lat), 32'd34);
      check({nm, " busy cycles"}, 32'(nbusy), 32'd33);
      check({nm, " busy at done"}, {31'd0, busy}, 32'd0);
      check({nm, " hi"}, hi, eh);
      check({nm, " lo"}, lo, el);
   endtask

   task automatic flush_test(input logic [31:0] eh, input logic [31:0] el);
      int ndone, nbusy;
      ndone = 0;
      nbusy = 0;
      op    = 2'd1;
      a     = 32'd3;
      b     = 32'd3;
      start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (done) ndone++;
         if (c == 10) check("flush busy before", {31'd0, busy}, 32'd1);
         if (c == 11) check("flush busy after", {31'd0, busy}, 32'd0);
         start = (c == 5);
         flush = (c == 10);
         if (c == 5) begin
            a = 32'd7;
            b = 32'd9;
         end
      end
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("flush no done", 32'(ndone), 32'd0);
      check("flush hi kept", hi, eh);
      check("flush lo kept", lo, el);

      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush+start busy", {31'd0, busy}, 32'd0);
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      check("flush+start no done", 32'(ndone), 32'd0);
      check("flush+start no busy", 32'(nbusy), 32'd0);
   endtask

   task automatic reset_test();
      int ndone;
      ndone = 0;
      op    = DivEn ? 2'd2 : 2'd0;
      a     = 32'h07654321;
      b     = 32'd13;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         rst   = (c == 20);
      end
      @(negedge clk);
      rst = 1'b0;
      check("mid-op reset busy", {31'd0, busy}, 32'd0);
      check("mid-op reset done", {31'd0, done}, 32'd0);
      check("mid-op reset hi", hi, 32'd0);
      check("mid-op reset lo", lo, 32'd0);
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mid-op reset no done", 32'(ndone), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hffffffff;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'd0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst    = 1'b0;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      @(negedge clk);

      run("multu max", 2'd1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001);
      run("mult -3*5", 2'd0, 32'hfffffffd, 32'd5, 32'hffffffff, 32'hfffffff1);
      if (DivEn) begin
         run("divu 100/7 b2b", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
         run("div -7/2", 2'd2, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd);
         run("div min/-1", 2'd2, 32'h80000000, 32'hffffffff, 32'd0, 32'h80000000);
         run("div by 0", 2'd2, 32'h12345678, 32'd0, 32'h12345678, 32'hffffffff);
         run("div neg by 0", 2'd2, 32'hfffffff0, 32'd0, 32'hfffffff0, 32'hffffffff);
         run("divu by 0", 2'd3, 32'hdeadbeef, 32'd0, 32'hdeadbeef, 32'hffffffff);
         run("divu base", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
         flush_test(32'd2, 32'd14);
      end else begin
         run("multu base", 2'd1, 32'h80000000, 32'd4, 32'd2, 32'd0);
         flush_test(32'd2, 32'd0);
      end

      reset_test();

      if (!DivEn) begin
         int nbusy, ndone;
         nbusy = 0;
         ndone = 0;
         for (int i = 0; i < 2; i++) begin
            op    = (i == 0) ? 2'd2 : 2'd3;
            a     = 32'd99;
            b     = 32'd5;
            start = 1'b1;
            repeat (40) begin
               @(negedge clk);
               start = 1'b0;
               if (busy) nbusy++;
               if (done) ndone++;
            end
         end
         check("div ignored busy", 32'(nbusy), 32'd0);
         check("div ignored done", 32'(ndone), 32'd0);
         check("div ignored hi", hi, 32'd0);
         check("div ignored lo", lo, 32'd0);
      end

      for (int i = 0; i < 6000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         flush = ($urandom_range(0, 79) == 0);
         start = ($urandom_range(0, 2) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = pick();
         b     = pick();
         @(negedge clk);
      end
      rst   = 1'b0;
      flush = 1'b0;
      start = 1'b0;
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_mdu.md
# mips_mdu

Iterative multiply/divide unit for the MIPS core's EX stage, implementing MULT, MULTU, DIV and DIVU. It owns the architectural HI/LO registers. Results are read by MFHI/MFLO and forwarded into the EX/MEM pipeline register. `busy` is used by the hazard unit to stall any dependent instruction.

## Interface
- `N`, default 32: operand width and HI/LO width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation. Sampled only in IDLE.
- `op`  in  2  operation code: 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`  in  N  rs operand (multiplicand or dividend).
- `b`  in  N  rt operand (multiplier or divisor).
- `flush`  in  1  abort any operation in flight (pipeline flush).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have been updated.
- `hi`  out  N  HI register (multiply upper half, or remainder).
- `lo`  out  N  LO register (multiply lower half, or quotient).

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, `start`=1, `flush`=0:**
  - Latch `op`.
  - Latch |a| and |b| (plain values for unsigned ops), plus the sign bits for signed ops.
  - Clear the 2N-bit accumulator and load the iteration counter with N-1.
  - Go to CALC.
- **CALC, multiply:** radix-2 shift-add, one bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle.
- **CALC exit:** the counter decrements each cycle; leave CALC for FIX after the cycle in which it equals 0.
- **FIX:** apply sign correction, write `hi`/`lo`, register `done`=1, return to IDLE.
- **Signed multiply:** negate the 2N-bit product when sign(a) XOR sign(b).
- **Signed divide:**
  - Negate the quotient when sign(a) XOR sign(b).
  - The remainder takes the sign of the dividend.
- **Divide by zero (b=0, signed or unsigned):** `hi`=a, `lo`={N{1}}. `done` and latency are unchanged.
- **DIV of most-negative by -1:** `lo`=most-negative value, `hi`=0 (wraps, no trap).
- **`start` while `busy`:** ignored. The operation in flight is unaffected.
- **`flush`:**
  - In any state, the next state is IDLE.
  - `hi`/`lo` keep their previous values and no `done` is generated.
  - `flush` and `start` in the same IDLE cycle: `flush` wins and the start is dropped.
- **Reset:** `rst` takes priority over everything. State=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. This applies also mid-operation.
- `hi`/`lo` change only in FIX or on reset.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Cycles 1..N: CALC, `busy`=1.
- Cycle N+1: FIX, `busy`=1.
- Cycle N+2:
  - `done`=1 and `busy`=0.
  - `hi`/`lo` hold the new result.
  - A new `start` is accepted in this same cycle.
- Latency from start to result is N+2 cycles (34 for N=32), identical for all ops including divide by zero.
- `busy` is a registered output, derived as state != IDLE.
- `done` is registered and high for exactly one cycle per completed operation.
- A `flush` in cycle k means `busy`=0 in cycle k+1.

## Configuration
- **`MIPS_MDU_DIV_EN` defined:** full behaviour as above.
- **`MIPS_MDU_DIV_EN` undefined:**
  - Divider datapath and divide-by-zero logic are removed.
  - `op`=10/11 with `start` is ignored: stays IDLE, no `busy`, no `done`, `hi`/`lo` unchanged.
  - Multiply behaviour and timing are identical.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` high in cycle 34 only; `busy` high cycles 1..33.
- MULT a=0xFFFFFFFD (-3), b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then back-to-back DIVU a=100, b=7 started in the `done` cycle -> `lo`=14, `hi`=2.
- DIV a=-7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV a=0x12345678, b=0 -> `hi`=0x12345678, `lo`=0xFFFFFFFF, after the full 34-cycle latency.
- Sequence: load `hi`=2, `lo`=14 from a prior DIVU, start MULTU 3x3, pulse `start` again in cycle 5 (must be ignored), assert `flush` in cycle 10.
  - Required: `busy`=0 in cycle 11, no `done`, `hi`/`lo` remain 2/14.
  - Repeat with `flush`+`start` together in IDLE -> no operation starts.
- Assert `rst` in cycle 20 of a DIV -> next cycle `busy`=0, `hi`=`lo`=0, no `done`. Without `MIPS_MDU_DIV_EN`, DIV `start` -> `busy` stays 0 for 40 cycles.
